// File: rtl/filt_chan_sched_pkg.sv
// Shared types and helpers for the filter channel scheduler (filt_chan_sched).
package fcs_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } fcs_state_e;

  localparam int CNT_W = 16;
  localparam int GAP_W = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/filt_chan_sched_if.sv
// Request, filter and result buses of filt_chan_sched. Handshake: a request sample
// moves on a rising edge where req_valid[c] & req_ready[c]; flt_stb/res_valid are unacknowledged strobes.
interface filt_chan_sched_if
  import fcs_pkg::*;
#(
  parameter int NCH = 4,
  parameter int W   = 15
);
  localparam int CW = clog2(NCH);

  logic [NCH-1:0]   req_valid;
  logic [NCH*W-1:0] req_data;
  logic [NCH-1:0]   req_ready;
  logic             flt_stb;
  logic [W-1:0]     flt_data;
  logic [CW-1:0]    flt_ch;
  logic [W-1:0]     flt_res;
  logic             res_valid;
  logic [CW-1:0]    res_ch;
  logic [W-1:0]     res_data;

  modport slave (
    input  req_valid, req_data, flt_res,
    output req_ready, flt_stb, flt_data, flt_ch, res_valid, res_ch, res_data
  );

  modport master (
    output req_valid, req_data, flt_res,
    input  req_ready, flt_stb, flt_data, flt_ch, res_valid, res_ch, res_data
  );

endinterface

// File: rtl/filt_chan_sched_rr_pick.sv
// Combinational round-robin picker: first valid channel at or after ptr, wrapping at NCH.
module fcs_rr_pick #(
  parameter int NCH = 4,
  parameter int CW  = 2
) (
  input  logic [NCH-1:0] valid,
  input  logic [CW-1:0]  ptr,
  output logic [CW-1:0]  winner,
  output logic           any
);

  // Scan from the farthest offset down so the nearest valid channel is written last.
  always_comb begin
    int idx;
    winner = '0;
    any    = 1'b0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = int'(ptr) + i;
      if (idx >= NCH) idx = idx - NCH;
      if (valid[idx]) begin
        winner = CW'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/filt_chan_sched.sv
// Round-robin scheduler sharing one filter among NCH channels, tagging results by channel.
// Optional per-channel grant counters with cnt_sel/cnt_val when FCS_GRANT_CNT_EN is defined.
module filt_chan_sched
  import fcs_pkg::*;
#(
  parameter int NCH      = 4,
  parameter int W        = 15,
  parameter int FILT_LAT = 1,
  parameter int GAP      = 1
) (
  input  logic                   clock_in,
  input  logic                   reset_n,
  filt_chan_sched_if.slave       bus,
  output logic                   busy,
  output logic [1:0]             state_dbg
`ifdef FCS_GRANT_CNT_EN
  ,
  input  logic [clog2(NCH)-1:0]  cnt_sel,
  output logic [CNT_W-1:0]       cnt_val
`endif
);

  localparam int CW = clog2(NCH);
  localparam logic [GAP_W-1:0] HOLD_LAST = GAP_W'(GAP - 2);

  fcs_state_e               state_q, state_d;
  logic [CW-1:0]            rr_q, rr_d;
  logic [GAP_W-1:0]         hold_cnt_q, hold_cnt_d;
  logic                     flt_stb_q, flt_stb_d;
  logic [W-1:0]             flt_data_q, flt_data_d;
  logic [CW-1:0]            flt_ch_q, flt_ch_d;
  logic [FILT_LAT-1:0]      pipe_stb_q, pipe_stb_d;
  logic [FILT_LAT-1:0][CW-1:0] pipe_ch_q, pipe_ch_d;
  logic [NCH-1:0]           req_ready;
  logic [CW-1:0]            win;
  logic                     win_any;

  fcs_rr_pick #(.NCH(NCH), .CW(CW)) u_pick (
    .valid  (bus.req_valid),
    .ptr    (rr_q),
    .winner (win),
    .any    (win_any)
  );

  // The winner is chosen in GRANT itself so a requester that drops valid simply loses the slot.
  always_comb begin
    state_d    = state_q;
    rr_d       = rr_q;
    hold_cnt_d = hold_cnt_q;
    flt_stb_d  = 1'b0;
    flt_data_d = flt_data_q;
    flt_ch_d   = flt_ch_q;
    req_ready  = '0;
    case (state_q)
      IDLE: begin
        if (|bus.req_valid) state_d = GRANT;
      end
      GRANT: begin
        if (win_any) begin
          req_ready[win] = 1'b1;
          flt_stb_d      = 1'b1;
          flt_data_d     = bus.req_data[int'(win)*W +: W];
          flt_ch_d       = win;
          rr_d           = (int'(win) == NCH - 1) ? '0 : win + CW'(1);
        end
        hold_cnt_d = '0;
        state_d    = (GAP > 1) ? HOLD : IDLE;
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = IDLE;
        else                         hold_cnt_d = hold_cnt_q + GAP_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  // Tag pipe lines up with the filter latency: stage 0 loads as flt_stb is seen by the filter.
  always_comb begin
    pipe_stb_d   = '0;
    pipe_ch_d    = '0;
    pipe_stb_d[0] = flt_stb_q;
    pipe_ch_d[0]  = flt_ch_q;
    for (int i = 1; i < FILT_LAT; i++) begin
      pipe_stb_d[i] = pipe_stb_q[i-1];
      pipe_ch_d[i]  = pipe_ch_q[i-1];
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      rr_q       <= '0;
      hold_cnt_q <= '0;
      flt_stb_q  <= 1'b0;
      flt_data_q <= '0;
      flt_ch_q   <= '0;
      pipe_stb_q <= '0;
      pipe_ch_q  <= '0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      hold_cnt_q <= hold_cnt_d;
      flt_stb_q  <= flt_stb_d;
      flt_data_q <= flt_data_d;
      flt_ch_q   <= flt_ch_d;
      pipe_stb_q <= pipe_stb_d;
      pipe_ch_q  <= pipe_ch_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.flt_stb   = flt_stb_q;
  assign bus.flt_data  = flt_data_q;
  assign bus.flt_ch    = flt_ch_q;
  assign bus.res_valid = pipe_stb_q[FILT_LAT-1];
  assign bus.res_ch    = pipe_stb_q[FILT_LAT-1] ? pipe_ch_q[FILT_LAT-1] : '0;
  assign bus.res_data  = pipe_stb_q[FILT_LAT-1] ? bus.flt_res : '0;
  assign busy          = (state_q != IDLE) | flt_stb_q | (|pipe_stb_q);
  assign state_dbg     = state_q;

`ifdef FCS_GRANT_CNT_EN
  logic [CNT_W-1:0] cnt_q [NCH];
  logic [CNT_W-1:0] cnt_d [NCH];

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      cnt_d[c] = cnt_q[c];
      if (flt_stb_d && (flt_ch_d == CW'(c)) && (cnt_q[c] != '1))
        cnt_d[c] = cnt_q[c] + CNT_W'(1);
    end
  end

  always_ff @(posedge clock_in or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < NCH; c++) cnt_q[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) cnt_q[c] <= cnt_d[c];
    end
  end

  assign cnt_val = (int'(cnt_sel) < NCH) ? cnt_q[cnt_sel] : '0;
`endif

endmodule
